// File: rtl/i2s_decoder.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA in the system clock domain and
// assembles MSB-first left/right words, emitting them as a paired sample with
// a one-cycle valid strobe. Words shorter than WIDTH are left-justified and
// flagged with a one-cycle short strobe at commit time.
module i2s_decoder #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CNT_BITS = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_i2s_bclk,
  input  logic             i_i2s_lrclk,
  input  logic             i_i2s_sdata,
  output logic [WIDTH-1:0] o_data_l,
  output logic [WIDTH-1:0] o_data_r,
  output logic             o_valid,
  output logic             o_short
);

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_e;

  localparam logic [CNT_BITS-1:0] WIDTH_C = CNT_BITS'(WIDTH);

  // Synchronizer stages and BCLK edge history
  logic bclk_s1_q, bclk_s1_d;
  logic bclk_s2_q, bclk_s2_d;
  logic bclk_prev_q, bclk_prev_d;
  logic lr_s1_q, lr_s1_d;
  logic lr_s2_q, lr_s2_d;
  logic sd_s1_q, sd_s1_d;
  logic sd_s2_q, sd_s2_d;

  // Decoder state
  state_e              state_q, state_d;
  logic                lr_q, lr_d;
  logic                cur_ch_q, cur_ch_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [WIDTH-1:0]    pend_l_q, pend_l_d;

  // Registered outputs
  logic [WIDTH-1:0]    data_l_q, data_l_d;
  logic [WIDTH-1:0]    data_r_q, data_r_d;
  logic                valid_q, valid_d;
  logic                short_q, short_d;

  // Combinational helpers
  logic                bclk_rise;
  logic                ch;
  logic                sd_bit;
  logic                boundary;
  logic                word_short;
  logic [CNT_BITS-1:0] cnt_base;
  logic [WIDTH-1:0]    shift_base;

  // Next-state computation: synchronizers, edge detect, word assembly and FSM
  always_comb begin
    bclk_s1_d   = i_i2s_bclk;
    bclk_s2_d   = bclk_s1_q;
    bclk_prev_d = bclk_s2_q;
    lr_s1_d     = i_i2s_lrclk;
    lr_s2_d     = lr_s1_q;
    sd_s1_d     = i_i2s_sdata;
    sd_s2_d     = sd_s1_q;

    state_d     = state_q;
    lr_d        = lr_q;
    cur_ch_d    = cur_ch_q;
    count_d     = count_q;
    shift_d     = shift_q;
    pend_l_d    = pend_l_q;
    data_l_d    = data_l_q;
    data_r_d    = data_r_q;
    valid_d     = 1'b0;
    short_d     = 1'b0;

    bclk_rise   = bclk_s2_q & ~bclk_prev_q;
    ch          = lr_q;
    sd_bit      = sd_s2_q;
    boundary    = (lr_q != cur_ch_q);
    word_short  = (count_q < WIDTH_C);
    cnt_base    = count_q;
    shift_base  = shift_q;

    if (bclk_rise) begin
      // The bit on this edge belongs to the channel seen one edge earlier
      lr_d = lr_s2_q;

      if (boundary) begin
        unique case (state_q)
          SEEK: begin
            if (!ch) state_d = LEFT;
          end
          LEFT: begin
            pend_l_d = shift_q;
            short_d  = word_short;
            state_d  = RIGHT;
          end
          RIGHT: begin
            data_l_d = pend_l_q;
            data_r_d = shift_q;
            valid_d  = 1'b1;
            short_d  = word_short;
            state_d  = LEFT;
          end
          default: state_d = SEEK;
        endcase
        // A boundary wins over saturation: restart the word with this bit as MSB
        cur_ch_d   = ch;
        cnt_base   = '0;
        shift_base = '0;
      end

      shift_d = shift_base;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (cnt_base == CNT_BITS'(WIDTH - 1 - i)) shift_d[i] = sd_bit;
      end
      count_d = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_prev_q <= 1'b0;
      lr_s1_q     <= 1'b0;
      lr_s2_q     <= 1'b0;
      sd_s1_q     <= 1'b0;
      sd_s2_q     <= 1'b0;
      state_q     <= SEEK;
      lr_q        <= 1'b0;
      cur_ch_q    <= 1'b0;
      count_q     <= '0;
      shift_q     <= '0;
      pend_l_q    <= '0;
      data_l_q    <= '0;
      data_r_q    <= '0;
      valid_q     <= 1'b0;
      short_q     <= 1'b0;
    end else begin
      bclk_s1_q   <= bclk_s1_d;
      bclk_s2_q   <= bclk_s2_d;
      bclk_prev_q <= bclk_prev_d;
      lr_s1_q     <= lr_s1_d;
      lr_s2_q     <= lr_s2_d;
      sd_s1_q     <= sd_s1_d;
      sd_s2_q     <= sd_s2_d;
      state_q     <= state_d;
      lr_q        <= lr_d;
      cur_ch_q    <= cur_ch_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      pend_l_q    <= pend_l_d;
      data_l_q    <= data_l_d;
      data_r_q    <= data_r_d;
      valid_q     <= valid_d;
      short_q     <= short_d;
    end
  end

  assign o_data_l = data_l_q;
  assign o_data_r = data_r_q;
  assign o_valid  = valid_q;
  assign o_short  = short_q;

endmodule

// File: tb/tb_i2s_decoder.sv
// Testbench for i2s_decoder: drives I2S frames and scores paired outputs.
`timescale 1ns/1ps
module tb_i2s_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i2s_bclk = 1'b0;
  logic        i2s_lrclk = 1'b0;
  logic        i2s_sdata = 1'b0;
  logic [15:0] o_data_l;
  logic [15:0] o_data_r;
  logic        o_valid;
  logic        o_short;

  int  checks = 0;
  int  errors = 0;
  int  short_cnt = 0;
  int  half = 40;
  logic prev_lsb = 1'b0;
  time left_msb_t = 0;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        sh;
  } exp_t;
  exp_t sb[$];

  i2s_decoder #(.WIDTH(16), .CNT_BITS(6)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_i2s_bclk (i2s_bclk),
    .i_i2s_lrclk(i2s_lrclk),
    .i_i2s_sdata(i2s_sdata),
    .o_data_l   (o_data_l),
    .o_data_r   (o_data_r),
    .o_valid    (o_valid),
    .o_short    (o_short)
  );

  always #5 clk = ~clk;

  // Expected 16-bit capture of an n-bit MSB-first word
  function automatic logic [15:0] trunc(input logic [31:0] w, input int n);
    logic [31:0] t;
    if (n >= 16) t = w >> (n - 16);
    else         t = w << (16 - n);
    return t[15:0];
  endfunction

  task automatic push_exp(input logic [31:0] l, input int nl,
                          input logic [31:0] r, input int nr);
    exp_t e;
    e.l  = trunc(l, nl);
    e.r  = trunc(r, nr);
    e.sh = (nr < 16);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; assert (o_data_l === 16'h0) else begin errors++; $error("FAIL rst_data_l got %h exp %h", o_data_l, 16'h0); end
    checks++; assert (o_data_r === 16'h0) else begin errors++; $error("FAIL rst_data_r got %h exp %h", o_data_r, 16'h0); end
    checks++; assert (o_valid === 1'b0) else begin errors++; $error("FAIL rst_valid got %b exp 0", o_valid); end
    checks++; assert (o_short === 1'b0) else begin errors++; $error("FAIL rst_short got %b exp 0", o_short); end
  endtask

  // One slot: data changes while BCLK is low, j=0 carries previous word's LSB
  task automatic send_slot(input logic c, input logic [31:0] w, input int n, input int rst_at);
    for (int j = 0; j < n; j++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = c;
      i2s_sdata = (j == 0) ? prev_lsb : w[n - j];
      if (j == rst_at) do_reset();
      #(half);
      i2s_bclk = 1'b1;
      if (c == 1'b0 && j == 1) left_msb_t = $time;
      #(half);
    end
    prev_lsb = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_slot(1'b0, l, n, -1);
    send_slot(1'b1, r, n, -1);
  endtask

  task automatic start_test(input int ratio);
    i2s_bclk = 1'b0;
    #20;
    do_reset();
    half = ratio * 5;
    #($urandom_range(1, 3));
    send_frame(32'h0000_5555, 32'h0000_AAAA, 16);  // alignment frame, never output
  endtask

  task automatic end_test(input int exp_short);
    i2s_bclk = 1'b0;
    #300;
    checks++; assert (sb.size() == 0) else begin errors++; $error("FAIL missing_valid got %0d pending exp 0", sb.size()); end
    checks++; assert (short_cnt == exp_short) else begin errors++; $error("FAIL short_count got %0d exp %0d", short_cnt, exp_short); end
    short_cnt = 0;
    sb.delete();
  endtask

  // Output monitor: pops scoreboard on every valid pulse
  logic        prev_valid = 1'b0;
  logic        prev_short = 1'b0;
  logic        prev_rst = 1'b0;
  logic [15:0] prev_l = '0;
  logic [15:0] prev_r = '0;
  exp_t        got_e;
  always @(negedge clk) begin
    if (!rst && !prev_rst && !o_valid) begin
      checks++;
      assert (o_data_l === prev_l && o_data_r === prev_r) else begin
        errors++; $error("FAIL hold got %h/%h exp %h/%h", o_data_l, o_data_r, prev_l, prev_r);
      end
    end
    if (o_valid) begin
      checks++; assert (prev_valid === 1'b0) else begin errors++; $error("FAIL valid_width got 2+ cycles exp 1"); end
      checks++; assert (sb.size() != 0) else begin errors++; $error("FAIL unexpected_valid got %h/%h exp none", o_data_l, o_data_r); end
      if (sb.size() != 0) begin
        got_e = sb.pop_front();
        checks++; assert (o_data_l === got_e.l) else begin errors++; $error("FAIL data_l got %h exp %h", o_data_l, got_e.l); end
        checks++; assert (o_data_r === got_e.r) else begin errors++; $error("FAIL data_r got %h exp %h", o_data_r, got_e.r); end
        checks++; assert (o_short === got_e.sh) else begin errors++; $error("FAIL short_at_valid got %b exp %b", o_short, got_e.sh); end
        checks++; assert ($time - left_msb_t <= 45) else begin errors++; $error("FAIL latency got %0t exp <= 45ns", $time - left_msb_t); end
      end
    end
    if (o_short) begin
      short_cnt++;
      checks++; assert (prev_short === 1'b0) else begin errors++; $error("FAIL short_width got 2+ cycles exp 1"); end
    end
    prev_valid = o_valid;
    prev_short = o_short;
    prev_rst   = rst;
    prev_l     = o_data_l;
    prev_r     = o_data_r;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic capture, 16-bit slots, BCLK = clk/8
    start_test(8);
    for (int k = 0; k < 3; k++) begin
      push_exp(32'h1234, 16, 32'hABCD, 16);
      send_frame(32'h1234, 32'hABCD, 16);
    end
    send_frame(32'h1234, 32'hABCD, 16);
    end_test(0);

    // Wide 32-bit slots are truncated to the top 16 bits
    start_test(8);
    for (int k = 0; k < 2; k++) begin
      push_exp(32'h89AB_CDEF, 32, 32'h00FF_1234, 32);
      send_frame(32'h89AB_CDEF, 32'h00FF_1234, 32);
    end
    send_frame(32'h89AB_CDEF, 32'h00FF_1234, 32);
    end_test(0);

    // Reset during a right slot: interrupted frame dropped, next full pair output
    start_test(6);
    push_exp(32'h0F0F, 16, 32'hF0F0, 16);
    send_frame(32'h0F0F, 32'hF0F0, 16);
    send_slot(1'b0, 32'h1111, 16, -1);
    send_slot(1'b1, 32'h2222, 16, 8);
    push_exp(32'h5A5A, 16, 32'hA5A5, 16);
    send_frame(32'h5A5A, 32'hA5A5, 16);
    push_exp(32'h3C3C, 16, 32'hC3C3, 16);
    send_frame(32'h3C3C, 32'hC3C3, 16);
    send_frame(32'h1234, 32'hABCD, 16);
    end_test(0);

    // Short 12-bit slots: left-justified, short on every commit
    start_test(6);
    for (int k = 0; k < 2; k++) begin
      push_exp(32'hFFF, 12, 32'h800, 12);
      send_frame(32'hFFF, 32'h800, 12);
    end
    send_frame(32'hFFF, 32'h800, 12);
    end_test(5);

    // LRCLK glitch: a one-bit left slot is a legal short word
    start_test(5);
    push_exp(32'h1, 1, 32'hBEEF, 16);
    send_slot(1'b0, 32'h1, 1, -1);
    send_slot(1'b1, 32'hBEEF, 16, -1);
    push_exp(32'h1234, 16, 32'hABCD, 16);
    send_frame(32'h1234, 32'hABCD, 16);
    send_frame(32'h1234, 32'hABCD, 16);
    end_test(1);

    // Extremes with random BCLK ratio and phase
    for (int it = 0; it < 4; it++) begin
      start_test(int'($urandom_range(4, 16)));
      for (int k = 0; k < 2; k++) begin
        push_exp(32'h8000, 16, 32'h7FFF, 16);
        send_frame(32'h8000, 32'h7FFF, 16);
      end
      send_frame(32'h8000, 32'h7FFF, 16);
      end_test(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
